// File: rtl/adpcm_stage_sequencer.sv
// Per-sample stage sequencer for the multi-channel ADPCM encoder datapath.
// Walks each channel through the compute stages on a frame tick, then strobes its delay-element update.
module adpcm_stage_sequencer #(
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2,
  parameter int NUM_STAGES = 6,
  parameter int SETTLE     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_start,
  input  logic [1:0]            rate,
  input  logic                  stall,
  input  logic                  clr_overrun,
  output logic [1:0]            rate_q,
  output logic [CH_W-1:0]       ch_sel,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  delay_update,
  output logic                  frame_busy,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam int STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int CNT_W = $clog2(SETTLE) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(NUM_STAGES - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {IDLE, LOAD, STAGE, UPDATE, NEXT_CH, DONE} state_t;

  state_t                state_reg, state_next;
  logic [STG_W-1:0]      stage_reg, stage_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [CH_W-1:0]       ch_next;
  logic [1:0]            rate_next;
  logic                  overrun_next;
  logic [NUM_STAGES-1:0] stage_en_next;
  logic                  delay_update_next;
  logic                  frame_busy_next;
  logic                  frame_done_next;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      stage_reg    <= '0;
      cnt_reg      <= '0;
      ch_sel       <= '0;
      rate_q       <= 2'b00;
      overrun      <= 1'b0;
      stage_en     <= '0;
      delay_update <= 1'b0;
      frame_busy   <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      stage_reg    <= stage_next;
      cnt_reg      <= cnt_next;
      ch_sel       <= ch_next;
      rate_q       <= rate_next;
      overrun      <= overrun_next;
      stage_en     <= stage_en_next;
      delay_update <= delay_update_next;
      frame_busy   <= frame_busy_next;
      frame_done   <= frame_done_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    stage_next = stage_reg;
    cnt_next   = cnt_reg;
    ch_next    = ch_sel;
    rate_next  = rate_q;
    case (state_reg)
      IDLE: begin
        if (sample_start) begin
          state_next = LOAD;
          rate_next  = rate;
          ch_next    = '0;
        end
      end
      LOAD: begin
        stage_next = '0;
        cnt_next   = '0;
        state_next = STAGE;
      end
      STAGE: begin
        if (!stall) begin
          if (cnt_reg != CNT_LAST) begin
            cnt_next = cnt_reg + 1'b1;
          end else if (stage_reg != STG_LAST) begin
            stage_next = stage_reg + 1'b1;
            cnt_next   = '0;
          end else begin
            state_next = UPDATE;
          end
        end
      end
      UPDATE: state_next = NEXT_CH;
      NEXT_CH: begin
        if (ch_sel == CH_LAST) begin
          state_next = DONE;
        end else begin
          ch_next    = ch_sel + 1'b1;
          stage_next = '0;
          cnt_next   = '0;
          state_next = STAGE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A tick arriving outside IDLE is dropped; its overrun set outranks a clear.
  always_comb begin
    overrun_next = overrun;
    if (sample_start && (state_reg != IDLE)) begin
      overrun_next = 1'b1;
    end else if (clr_overrun) begin
      overrun_next = 1'b0;
    end
  end

  // Outputs decoded from the upcoming state so the registers track the current state
  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage_en
      assign stage_en_next[gi] = (state_next == STAGE) && (stage_next == STG_W'(gi));
    end
  endgenerate

  always_comb begin
    delay_update_next = (state_next == UPDATE);
    frame_busy_next   = (state_next != IDLE);
    frame_done_next   = (state_next == DONE);
  end

endmodule

// File: tb/tb_adpcm_stage_sequencer.sv
// Bench for adpcm_stage_sequencer: randomized frames checked cycle by cycle against a
// frame schedule generated from the channel/stage/settle rules, plus a small-parameter instance.
module tb_adpcm_stage_sequencer;

  localparam int NUM_CH = 4, CH_W = 2, NUM_STAGES = 6, SETTLE = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sample_start = 1'b0;
  logic [1:0] rate = 2'b00;
  logic stall = 1'b0;
  logic clr_overrun = 1'b0;
  logic [1:0] rate_q;
  logic [CH_W-1:0] ch_sel;
  logic [NUM_STAGES-1:0] stage_en;
  logic delay_update, frame_busy, frame_done, overrun;

  logic s_start = 1'b0;
  logic [1:0] s_rate = 2'b01;
  logic s_stall = 1'b0;
  logic s_clr = 1'b0;
  logic [1:0] s_rate_q;
  logic [0:0] s_ch;
  logic [2:0] s_en;
  logic s_du, s_busy, s_done, s_ov;

  int total = 0;
  int bad = 0;
  logic ov_exp = 1'b0;

  always #5 clk = ~clk;

  adpcm_stage_sequencer #(.NUM_CH(NUM_CH), .CH_W(CH_W), .NUM_STAGES(NUM_STAGES), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .sample_start(sample_start), .rate(rate), .stall(stall),
    .clr_overrun(clr_overrun), .rate_q(rate_q), .ch_sel(ch_sel), .stage_en(stage_en),
    .delay_update(delay_update), .frame_busy(frame_busy), .frame_done(frame_done), .overrun(overrun)
  );

  adpcm_stage_sequencer #(.NUM_CH(1), .CH_W(1), .NUM_STAGES(3), .SETTLE(1)) dut_small (
    .clk(clk), .reset(reset), .sample_start(s_start), .rate(s_rate), .stall(s_stall),
    .clr_overrun(s_clr), .rate_q(s_rate_q), .ch_sel(s_ch), .stage_en(s_en),
    .delay_update(s_du), .frame_busy(s_busy), .frame_done(s_done), .overrun(s_ov)
  );

  typedef struct packed {
    logic [NUM_STAGES-1:0] en;
    logic                  du;
    logic [CH_W-1:0]       ch;
    logic                  busy;
    logic                  done;
  } exp_t;

  function automatic exp_t mk(int en, bit du, int ch, bit busy, bit done);
    exp_t e;
    e.en   = NUM_STAGES'(en);
    e.du   = du;
    e.ch   = CH_W'(ch);
    e.busy = busy;
    e.done = done;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({stage_en, delay_update, ch_sel, frame_busy, frame_done});
  endfunction

  // One frame: the schedule is LOAD, then per channel each stage held for SETTLE
  // unstalled cycles, an update cycle and a channel-advance cycle, then DONE.
  task automatic run_frame(input logic [1:0] r, input int stall_pct,
                           input int tick_a, input int tick_b, input int clr_at, input int rst_at,
                           input int fch, input int fst, input int fn);
    exp_t q[$];
    bit   sq[$];
    int   du_cnt = 0;
    int   busy_cnt = 0;
    q.push_back(mk(0, 0, 0, 1, 0));
    sq.push_back(1'b0);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int st = 0; st < NUM_STAGES; st++) begin
        int need = SETTLE;
        int forced = (ch == fch && st == fst) ? fn : 0;
        while (need > 0) begin
          bit s;
          if (forced > 0) begin
            s = 1'b1;
            forced--;
          end else begin
            s = ($urandom_range(99) < stall_pct);
          end
          q.push_back(mk(1 << st, 0, ch, 1, 0));
          sq.push_back(s);
          if (!s) need--;
        end
      end
      q.push_back(mk(0, 1, ch, 1, 0));
      sq.push_back($urandom_range(1) == 1);
      q.push_back(mk(0, 0, ch, 1, 0));
      sq.push_back(1'b0);
    end
    q.push_back(mk(0, 0, NUM_CH - 1, 1, 1));
    sq.push_back(1'b0);

    sample_start = 1'b1;
    rate = r;
    @(posedge clk); #1;
    sample_start = 1'b0;
    for (int k = 0; k < q.size(); k++) begin
      bit tick, clr;
      check($sformatf("out_k%0d", k), outs(), 32'(q[k]));
      check($sformatf("rate_q_k%0d", k), 32'(rate_q), 32'(r));
      check($sformatf("overrun_k%0d", k), 32'(overrun), 32'(ov_exp));
      if (delay_update === 1'b1) du_cnt++;
      if (frame_busy === 1'b1) busy_cnt++;
      if (k == rst_at) begin
        reset = 1'b0;
        stall = 1'b0;
        @(posedge clk); #1;
        check("reset_mid_outs", outs(), 32'(mk(0, 0, 0, 0, 0)));
        check("reset_mid_rate", 32'(rate_q), 32'd0);
        check("reset_mid_ov", 32'(overrun), 32'd0);
        repeat (3) begin
          @(posedge clk); #1;
          check("reset_hold_du", 32'(delay_update), 32'd0);
        end
        reset = 1'b1;
        ov_exp = 1'b0;
        $display("frame rate=%b aborted at cycle %0d updates=%0d", r, k + 1, du_cnt);
        return;
      end
      tick = (k == tick_a) || (k == tick_b);
      clr  = (k == clr_at);
      sample_start = tick;
      clr_overrun  = clr;
      stall = sq[k];
      rate  = 2'($urandom);
      @(posedge clk); #1;
      if (tick) ov_exp = 1'b1;
      else if (clr) ov_exp = 1'b0;
      sample_start = 1'b0;
      clr_overrun  = 1'b0;
    end
    stall = 1'b0;
    check("idle_after_frame", outs(), 32'(mk(0, 0, NUM_CH - 1, 0, 0)));
    check("update_count", 32'(du_cnt), 32'(NUM_CH));
    check("busy_cycles", 32'(busy_cnt), 32'(q.size()));
    $display("frame rate=%b cycles=%0d updates=%0d overrun=%b", r, busy_cnt, du_cnt, overrun);
  endtask

  initial begin
    logic [5:0] sexp [7];
    sexp[0] = 6'b000_0_1_0; sexp[1] = 6'b001_0_1_0; sexp[2] = 6'b010_0_1_0;
    sexp[3] = 6'b100_0_1_0; sexp[4] = 6'b000_1_1_0; sexp[5] = 6'b000_0_1_0;
    sexp[6] = 6'b000_0_1_1;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", outs(), 32'(mk(0, 0, 0, 0, 0)));
    check("reset_rate", 32'(rate_q), 32'd0);
    check("reset_ov", 32'(overrun), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Plain frame at rate 10
    run_frame(2'b10, 0, -1, -1, -1, -1, -1, -1, 0);
    // Three stall cycles in channel 2 stage 4
    run_frame(2'b00, 0, -1, -1, -1, -1, 2, 4, 3);
    // Ticks on frame cycles 20 and 58 (DONE) rejected; clear in DONE loses to the set
    run_frame(2'b11, 0, 19, 57, 57, -1, -1, -1, 0);
    check("ov_sticky_idle", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;
    ov_exp = 1'b0;
    check("ov_cleared", 32'(overrun), 32'd0);
    // Reset on frame cycle 30, then full frames with rate 01 and 11
    run_frame(2'b10, 0, -1, -1, -1, 29, -1, -1, 0);
    run_frame(2'b01, 0, -1, -1, -1, -1, -1, -1, 0);
    run_frame(2'b11, 0, -1, -1, -1, -1, -1, -1, 0);
    // Random stalls and rates
    for (int f = 0; f < 3; f++) begin
      run_frame(2'($urandom), 25, -1, -1, -1, -1, -1, -1, 0);
    end

    // Single channel, three stages, settle of one
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check($sformatf("small_k%0d", k), 32'({s_en, s_du, s_busy, s_done}), 32'(sexp[k]));
      check($sformatf("small_ch_k%0d", k), 32'(s_ch), 32'd0);
      @(posedge clk); #1;
    end
    check("small_idle", 32'({s_en, s_du, s_busy, s_done}), 32'd0);
    check("small_rate", 32'(s_rate_q), 32'd1);
    $display("small frame cycles=7 rate_q=%b", s_rate_q);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
